// File: rtl/vline_counter.sv
// Vertical line counter for the vsync stage: counts line strobes, clears on the
// vsync request, and reports frame lock, frame-start pulses, frame number and overrun.
module vline_counter #(
  parameter int busWidth   = 11,
  parameter int limitLines = 2**busWidth - 1,
  parameter int frameBits  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 lineDone,
  input  logic                 countEnable,
  input  logic                 vCountReset_n,
  output logic [busWidth-1:0]  counterVal,
  output logic                 frameStart,
  output logic [frameBits-1:0] frameCount,
  output logic                 locked,
  output logic                 overrun
);

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    COUNT     = 1'b1
  } state_e;

  localparam logic [busWidth-1:0] LIMIT = limitLines[busWidth-1:0];

  state_e               state_q, state_d;
  logic [busWidth-1:0]  counter_q, counter_d;
  logic                 frame_start_q, frame_start_d;
  logic [frameBits-1:0] frame_count_q, frame_count_d;
  logic                 locked_q, locked_d;
  logic                 overrun_q, overrun_d;
  logic                 vres_prev_q, vres_prev_d;

  logic v_fall;
  logic incr;

  assign v_fall = vres_prev_q & ~vCountReset_n;
  assign incr   = lineDone & countEnable;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d       = state_q;
    counter_d     = counter_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    locked_d      = locked_q;
    overrun_d     = overrun_q;
    vres_prev_d   = vCountReset_n;

    if (!vCountReset_n) begin
      // The clear level wins over any strobe; only its leading edge is a frame event.
      counter_d = '0;
      if (v_fall) begin
        frame_start_d = 1'b1;
        case (state_q)
          SYNC_WAIT: begin
            state_d  = COUNT;
            locked_d = 1'b1;
          end
          COUNT:     frame_count_d = frame_count_q + 1'b1;
          default:   state_d = SYNC_WAIT;
        endcase
      end
    end else if (incr) begin
      if (counter_q == LIMIT) begin
        counter_d = '0;
        overrun_d = 1'b1;
        locked_d  = 1'b0;
        state_d   = SYNC_WAIT;
      end else begin
        counter_d = counter_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!reset_n) begin
      state_q       <= SYNC_WAIT;
      counter_q     <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      locked_q      <= 1'b0;
      overrun_q     <= 1'b0;
      vres_prev_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      locked_q      <= locked_d;
      overrun_q     <= overrun_d;
      vres_prev_q   <= vres_prev_d;
    end
  end

  assign counterVal = counter_q;
  assign frameStart = frame_start_q;
  assign frameCount = frame_count_q;
  assign locked     = locked_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_vline_counter.sv
// Directed bench for vline_counter: a full-width instance for counting, lock and the
// closed vsync loop, and a 4-bit instance for the watchdog ceiling.
module tb_vline_counter;

  localparam int RES_V = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Full-width instance
  logic        reset_n, lineDone, countEnable, v_man_n, loop_mode, vsync_q;
  logic        vCountReset_n;
  logic [10:0] counterVal;
  logic        frameStart, locked, overrun;
  logic [7:0]  frameCount;

  // Small instance for the watchdog
  logic        w_rst_n, w_line, w_clr_n;
  logic [3:0]  w_cv;
  logic        w_fs, w_locked, w_ov;
  logic [7:0]  w_fc;

  int checks   = 0;
  int failures = 0;

  assign vCountReset_n = loop_mode ? vsync_q : v_man_n;

  // Registered vsync stage model closing the loop
  always @(posedge clock) begin
    if (!reset_n) vsync_q <= 1'b1;
    else          vsync_q <= !(counterVal == 11'(RES_V));
  end

  vline_counter dut (
    .clock(clock), .reset_n(reset_n), .lineDone(lineDone), .countEnable(countEnable),
    .vCountReset_n(vCountReset_n), .counterVal(counterVal), .frameStart(frameStart),
    .frameCount(frameCount), .locked(locked), .overrun(overrun)
  );

  vline_counter #(.busWidth(4), .limitLines(15)) dut_w (
    .clock(clock), .reset_n(w_rst_n), .lineDone(w_line), .countEnable(1'b1),
    .vCountReset_n(w_clr_n), .counterVal(w_cv), .frameStart(w_fs),
    .frameCount(w_fc), .locked(w_locked), .overrun(w_ov)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe();
    lineDone = 1'b1; tick();
    lineDone = 1'b0; tick();
  endtask

  task automatic w_strobe();
    w_line = 1'b1; tick();
    w_line = 1'b0; tick();
  endtask

  initial begin
    int pulses, peak, cyc, cv, prev_cv, seq_err;
    logic prev_fs;

    loop_mode = 1'b0; countEnable = 1'b1;
    w_rst_n = 1'b0; w_line = 1'b0; w_clr_n = 1'b1;

    // Reset dominates active inputs
    reset_n = 1'b0; lineDone = 1'b1; v_man_n = 1'b0;
    tick(); tick();
    check("rst_cv", counterVal, 0);
    check("rst_fs", frameStart, 0);
    check("rst_fc", frameCount, 0);
    check("rst_locked", locked, 0);
    check("rst_ov", overrun, 0);

    // Counting and enable
    reset_n = 1'b1; lineDone = 1'b0; v_man_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) strobe();
    check("count5", counterVal, 5);
    countEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe();
      check("hold5", counterVal, 5);
    end
    check("unlocked", locked, 0);
    countEnable = 1'b1;

    // Lock: clear held three cycles gives a single pulse
    v_man_n = 1'b0; tick();
    check("lock_cv", counterVal, 0);
    check("lock_fs", frameStart, 1);
    check("lock_locked", locked, 1);
    check("lock_fc", frameCount, 0);
    tick();
    check("lock_fs_low1", frameStart, 0);
    tick();
    check("lock_fs_low2", frameStart, 0);
    check("lock_cv_held", counterVal, 0);
    v_man_n = 1'b1; tick();
    for (int i = 0; i < 10; i++) strobe();
    check("count10", counterVal, 10);
    v_man_n = 1'b0; tick();
    check("frame1_cv", counterVal, 0);
    check("frame1_fs", frameStart, 1);
    check("frame1_fc", frameCount, 1);
    tick();
    check("frame1_fs_low", frameStart, 0);
    v_man_n = 1'b1; tick();

    // Collision: clear edge beats the strobe
    for (int i = 0; i < 7; i++) strobe();
    check("count7", counterVal, 7);
    lineDone = 1'b1; v_man_n = 1'b0; tick();
    check("coll_cv", counterVal, 0);
    check("coll_fs", frameStart, 1);
    check("coll_fc", frameCount, 2);
    lineDone = 1'b0; v_man_n = 1'b1; tick();
    check("coll_after", counterVal, 0);

    // Mid-frame reset with a clear edge and strobe pending
    strobe(); strobe();
    reset_n = 1'b0; lineDone = 1'b1; v_man_n = 1'b0; tick();
    check("midrst_cv", counterVal, 0);
    check("midrst_fs", frameStart, 0);
    check("midrst_fc", frameCount, 0);
    check("midrst_locked", locked, 0);
    lineDone = 1'b0; v_man_n = 1'b1;

    // Watchdog on the 4-bit instance
    w_rst_n = 1'b1; tick();
    w_clr_n = 1'b0; tick();
    check("w_lock", w_locked, 1);
    w_clr_n = 1'b1; tick();
    w_clr_n = 1'b0; tick();
    check("w_fc1", w_fc, 1);
    w_clr_n = 1'b1; tick();
    for (int i = 0; i < 15; i++) w_strobe();
    check("w_cv15", w_cv, 15);
    check("w_ov_pre", w_ov, 0);
    w_line = 1'b1; tick();
    check("w_wrap_cv", w_cv, 0);
    check("w_wrap_ov", w_ov, 1);
    check("w_wrap_locked", w_locked, 0);
    w_line = 1'b0; tick();
    w_strobe();
    check("w_cv1", w_cv, 1);
    check("w_ov_sticky", w_ov, 1);
    w_clr_n = 1'b0; tick();
    check("w_relock", w_locked, 1);
    check("w_relock_fs", w_fs, 1);
    check("w_relock_fc", w_fc, 1);
    check("w_relock_cv", w_cv, 0);
    w_clr_n = 1'b1; tick();
    check("w_ov_final", w_ov, 1);

    // Closed loop with the vsync model, strobe every third cycle
    reset_n = 1'b0; loop_mode = 1'b1; tick();
    reset_n = 1'b1;
    pulses = 0; peak = 0; cyc = 0; prev_cv = 0; seq_err = 0; prev_fs = 1'b0;
    while (pulses < 258 && cyc < 10000) begin
      lineDone = (cyc % 3 == 0);
      tick();
      cyc++;
      cv = int'(counterVal);
      if (cv > RES_V || !(cv == prev_cv || cv == prev_cv + 1 || (cv == 0 && prev_cv == RES_V)))
        seq_err++;
      if (frameStart && prev_fs) seq_err++;
      if (cv > peak) peak = cv;
      if (frameStart) begin
        check("loop_peak", peak, RES_V);
        check("loop_fc", frameCount, pulses % 256);
        pulses++;
        peak = 0;
      end
      prev_fs = frameStart;
      prev_cv = cv;
    end
    lineDone = 1'b0;
    if (pulses < 258) check("loop_timeout", pulses, 258);
    check("loop_seq", seq_err, 0);
    check("loop_locked", locked, 1);
    check("loop_ov", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vline_counter.md
# vline_counter

Vertical line counter feeding the vertical sync stage. It counts completed horizontal lines (one `lineDone` strobe per line) and presents the count on `counterVal`. The vsync stage compares that count against the vertical resolution. The counter clears on the vsync stage's active-low `vCountReset_n` request. It also reports frame lock, a frame-start pulse, a rolling frame number and a sticky overrun flag for missing vsync resets.

## Interface

Parameters:
- `busWidth`, 11, width of `counterVal`; must match the vsync stage.
- `limitLines`, 2**busWidth-1 (2047), watchdog ceiling for `counterVal`.
- `frameBits`, 8, width of `frameCount`.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset; highest priority.
- `lineDone`  in  1  one-cycle strobe per completed horizontal line.
- `countEnable`  in  1  high = count `lineDone` strobes; low = hold.
- `vCountReset_n`  in  1  active-low clear request from the vsync stage (level, may persist several cycles).
- `counterVal`  out  busWidth  current line number, registered.
- `frameStart`  out  1  one-cycle pulse at each frame boundary.
- `frameCount`  out  frameBits  frames completed since lock; wraps.
- `locked`  out  1  high once the first vsync clear has been seen.
- `overrun`  out  1  sticky; the watchdog ceiling was hit.

## Operation

- All outputs are registered. One clock; reset is synchronous and active-low.
- Reset (`reset_n` low at a rising edge) sets:
  - state = SYNC_WAIT;
  - `counterVal`=0, `frameStart`=0, `frameCount`=0, `locked`=0, `overrun`=0;
  - internal `vCountReset_n` previous-sample register = 1.
- Clear priority, highest first: `reset_n` > `vCountReset_n` low > watchdog wrap > increment > hold.
- Increment condition: `lineDone` & `countEnable`; result is `counterVal`+1.
- While `vCountReset_n` is low, `counterVal` is forced to 0 every cycle and `lineDone` is ignored.
- A falling edge is detected as previous sample = 1 and current = 0. Only a falling edge produces frame events; holding the line low for several cycles gives one event.
- States:
  - SYNC_WAIT: counts lines normally, so the vsync stage can eventually fire.
    - On falling edge of `vCountReset_n`: go to COUNT, `locked`<=1, `frameStart`<=1.
    - `frameCount` is not incremented on this locking edge.
  - COUNT: on falling edge of `vCountReset_n`: `frameStart`<=1, `frameCount`<=`frameCount`+1, modulo 2**frameBits.
- Watchdog: on an increment with `counterVal`==`limitLines`:
  - `counterVal`<=0, `overrun`<=1;
  - `locked`<=0, state<=SYNC_WAIT.
  - `overrun` clears only on reset.
- `countEnable` low freezes counting only. Clears, frame events and lock still operate.
- `frameStart` is high for exactly one cycle per event and low otherwise.

## Timing

- Increment latency: `lineDone` sampled at edge N gives the new `counterVal` visible after edge N.
- Clear latency: `vCountReset_n` low sampled at edge N gives `counterVal`=0 and `frameStart`=1 after edge N. `frameStart` returns to 0 after edge N+1.
- Closed loop with the registered vsync stage:
  - `counterVal` reaches `resVertical` after edge N;
  - vsync drives `vCountReset_n` low after N+1;
  - counter is 0 after N+2;
  - vsync releases after N+3;
  - counting resumes from 0 on the first strobe sampled at N+4 or later.
- Simultaneous `lineDone` and `vCountReset_n` low: the clear wins; the strobe is dropped.
- Reset mid-frame: all outputs return to their reset values on the next edge, regardless of other inputs.
- No combinational path from any input to any output.

## Test plan

- Reset check: hold `reset_n` low 2 cycles with `lineDone`=1 and `vCountReset_n`=0. Required: `counterVal`=0, `frameStart`=0, `frameCount`=0, `locked`=0, `overrun`=0.
- Counting and enable: 5 `lineDone` strobes with `countEnable`=1, then 3 strobes with `countEnable`=0. Required: `counterVal`=5 throughout the second group.
- Lock and frame count: `vCountReset_n` low for 3 cycles, release, 10 strobes, then low again. Required: `counterVal`=0 and a single 1-cycle `frameStart` pulse each time. After the first low: `locked`=1, `frameCount`=0. After the second low: `frameCount`=1. Counter reads 10 before the second clear.
- Collision: `lineDone`=1 in the same cycle as the falling edge of `vCountReset_n`, with `counterVal`=7. Required: `counterVal`=0 next cycle, never 8.
- Watchdog (busWidth=4, limitLines=15), while locked: 16 strobes with no clear. Required: `counterVal`=15, then 0; `overrun`=1 and stays 1; `locked`=0. The next clear relocks with `frameCount` unchanged.
- Closed loop with the vsync stage (resVertical=4), strobe every 3 cycles. Required: `counterVal` sequence 0..4 then 0, repeating; one `frameStart` per frame; `frameCount` wraps 255→0 after 256 frames.
